// File: rtl/lcd_spi_write.sv
// ---------------------------------------------------------------------------
// lcd_spi_write
//   Serializes 9-bit LCD words ({dc, byte}) onto a 4-wire SPI bus, mode 0,
//   MSB first. One word per handshake, no buffering. The wr_done pulse is
//   what upstream draw producers count to advance their word/pixel counters.
//
// Parameters
//   CLK_DIV   sys_clk cycles per SCLK half-period (1..255)
//
// Configuration macro
//   LCD_SPI_CS_KEEP_EN  when defined, chip select stays low across
//                       back-to-back words and only rises when IDLE sees
//                       no pending request.
//
// Ports
//   sys_clk    in   system clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   data[8:0]  in   bit8 = DC (1 data, 0 command), bits7:0 = byte
//   en_write   in   level request, word pending while high
//   wr_done    out  one-cycle pulse after the last bit period
//   busy       out  high from capture through the gap cycle
//   lcd_cs_n   out  chip select, active-low
//   lcd_dc     out  registered DC of the captured word
//   lcd_sclk   out  SPI clock, idle low
//   lcd_mosi   out  serial data
// ---------------------------------------------------------------------------
module lcd_spi_write #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [8:0] data,
  input  logic       en_write,
  output logic       wr_done,
  output logic       busy,
  output logic       lcd_cs_n,
  output logic       lcd_dc,
  output logic       lcd_sclk,
  output logic       lcd_mosi
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

`ifdef LCD_SPI_CS_KEEP_EN
  localparam logic CS_KEEP = 1'b1;
`else
  localparam logic CS_KEEP = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             dc_q, dc_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // Next-state and next-output logic for the serializer FSM.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    dc_d    = dc_q;
    done_d  = 1'b0;
    busy_d  = busy_q;

    case (state_q)
      // The edge that ends GAP is the edge at which IDLE samples the next
      // request; evaluating the capture here keeps the back-to-back word
      // period at 17*CLK_DIV+2 cycles.
      ST_IDLE, ST_GAP: begin
        if (en_write) begin
          state_d = ST_SETUP;
          shift_d = data[7:0];
          dc_d    = data[8];
          mosi_d  = data[7];
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          sclk_d  = 1'b0;
          div_d   = DIV_LOAD;
          bit_d   = 3'd0;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cs_n_d  = 1'b1;
        end
      end

      ST_SETUP: begin
        if (div_q == DIV_ZERO) begin
          state_d = ST_SHIFT;
          sclk_d  = 1'b1;
          div_d   = DIV_LOAD;
        end else begin
          div_d = div_q - DIV_ONE;
        end
      end

      // sclk_q doubles as the phase flag: 1 = high phase, 0 = low phase.
      ST_SHIFT: begin
        if (div_q != DIV_ZERO) begin
          div_d = div_q - DIV_ONE;
        end else begin
          div_d = DIV_LOAD;
          if (sclk_q) begin
            sclk_d = 1'b0;
            // After bit 0 has been sent MOSI simply holds.
            if (bit_q != 3'd7) begin
              mosi_d  = shift_q[6];
              shift_d = {shift_q[6:0], 1'b0};
            end else begin
              shift_d = shift_q;
            end
          end else begin
            if (bit_q == 3'd7) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              if (!CS_KEEP) begin
                cs_n_d = 1'b1;
              end else begin
                cs_n_d = cs_n_q;
              end
            end else begin
              bit_d  = bit_q + 3'd1;
              sclk_d = 1'b1;
            end
          end
        end
      end

      ST_DONE: begin
        state_d = ST_GAP;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= DIV_ZERO;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      dc_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      dc_q    <= dc_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign wr_done  = done_q;
  assign busy     = busy_q;
  assign lcd_cs_n = cs_n_q;
  assign lcd_dc   = dc_q;
  assign lcd_sclk = sclk_q;
  assign lcd_mosi = mosi_q;

endmodule

// File: tb/tb_lcd_spi_write.sv
// ---------------------------------------------------------------------------
// tb_lcd_spi_write
//   Self-checking bench for lcd_spi_write. Two instances: index 0 with
//   CLK_DIV=2 and index 1 with CLK_DIV=1. Expected words and their capture
//   edges are queued when a request is driven; a monitor rebuilds each byte
//   from MOSI at SCLK rises and checks it, plus the timing, when wr_done fires.
// ---------------------------------------------------------------------------
module tb_lcd_spi_write;

`ifdef LCD_SPI_CS_KEEP_EN
  localparam logic CS_AT_DONE = 1'b0;
  localparam logic CS_AT_GAP  = 1'b0;
`else
  localparam logic CS_AT_DONE = 1'b1;
  localparam logic CS_AT_GAP  = 1'b1;
`endif

  typedef struct packed {
    logic [8:0] w;
    int         t0;
  } exp_t;

  typedef struct packed {
    logic [8:0] w;
    logic       exp_dc;
    logic [7:0] exp_byte;
  } vec_t;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [8:0] data_a, data_b;
  logic       en_a, en_b;
  logic [1:0] done_w, busy_w, cs_w, dc_w, sclk_w, mosi_w;

  int cyc;
  int n_pass;
  int n_total;

  exp_t       q0[$];
  exp_t       q1[$];
  logic       prev_sclk [2];
  logic [7:0] rx        [2];
  int         rises     [2];
  int         first_rise[2];
  int         last_rise [2];

  lcd_spi_write #(.CLK_DIV(2)) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .data(data_a), .en_write(en_a),
    .wr_done(done_w[0]), .busy(busy_w[0]), .lcd_cs_n(cs_w[0]), .lcd_dc(dc_w[0]),
    .lcd_sclk(sclk_w[0]), .lcd_mosi(mosi_w[0])
  );

  lcd_spi_write #(.CLK_DIV(1)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .data(data_b), .en_write(en_b),
    .wr_done(done_w[1]), .busy(busy_w[1]), .lcd_cs_n(cs_w[1]), .lcd_dc(dc_w[1]),
    .lcd_sclk(sclk_w[1]), .lcd_mosi(mosi_w[1])
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total = n_total + 1;
    if (act == exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  // Monitor for one instance, run on every falling sys_clk edge.
  task automatic mon(input int d, input int cd);
    exp_t e;
    if (sclk_w[d] && !prev_sclk[d]) begin
      rx[d] = {rx[d][6:0], mosi_w[d]};
      if (rises[d] == 0) first_rise[d] = cyc;
      last_rise[d] = cyc;
      rises[d] = rises[d] + 1;
    end
    prev_sclk[d] = sclk_w[d];
    if (done_w[d]) begin
      if (qsize(d) == 0) begin
        chk($sformatf("unexpected_wr_done%0d", d), 1, 0);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("word%0d", d), int'({dc_w[d], rx[d]}), int'(e.w));
        chk($sformatf("sclk_rises%0d", d), rises[d], 8);
        chk($sformatf("first_rise%0d", d), first_rise[d], e.t0 + cd);
        chk($sformatf("sclk_span%0d", d), last_rise[d] - first_rise[d], 14 * cd);
        chk($sformatf("done_cycle%0d", d), cyc, e.t0 + 17 * cd);
        chk($sformatf("cs_at_done%0d", d), int'(cs_w[d]), int'(CS_AT_DONE));
      end
      rises[d] = 0;
    end
  endtask

  task automatic step();
    @(negedge sys_clk);
    mon(0, 2);
    mon(1, 1);
  endtask

  task automatic clear_mon();
    for (int d = 0; d < 2; d++) begin
      prev_sclk[d] = 1'b0;
      rx[d]        = 8'd0;
      rises[d]     = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  // Step until the instance's scoreboard drains (ends on the DONE cycle).
  task automatic wait_done(input int d);
    for (int i = 0; i < 200; i++) begin
      if (qsize(d) == 0) break;
      step();
    end
    if (qsize(d) != 0) begin
      chk($sformatf("timeout_wr_done%0d", d), qsize(d), 0);
      if (d == 0) q0.delete(); else q1.delete();
    end
  endtask

  // One word, request pulsed for one cycle, then check GAP and IDLE framing.
  task automatic send(input int d, input logic [8:0] w, input logic [8:0] exp);
    exp_t e;
    e.w  = exp;
    e.t0 = cyc + 1;
    if (d == 0) begin
      data_a = w; en_a = 1'b1; q0.push_back(e);
    end else begin
      data_b = w; en_b = 1'b1; q1.push_back(e);
    end
    step();
    if (d == 0) begin
      en_a = 1'b0; data_a = ~w;
    end else begin
      en_b = 1'b0; data_b = ~w;
    end
    chk($sformatf("busy_after_capture%0d", d), int'(busy_w[d]), 1);
    chk($sformatf("dc_after_capture%0d", d), int'(dc_w[d]), int'(exp[8]));
    wait_done(d);
    step();
    chk($sformatf("cs_in_gap%0d", d), int'(cs_w[d]), int'(CS_AT_GAP));
    chk($sformatf("busy_in_gap%0d", d), int'(busy_w[d]), 1);
    step();
    chk($sformatf("cs_idle%0d", d), int'(cs_w[d]), 1);
    chk($sformatf("busy_idle%0d", d), int'(busy_w[d]), 0);
  endtask

  initial begin
    vec_t vecs[5];
    exp_t e;
    int   t0;

    vecs[0] = '{w: 9'h02A, exp_dc: 1'b0, exp_byte: 8'h2A};
    vecs[1] = '{w: 9'h1F8, exp_dc: 1'b1, exp_byte: 8'hF8};
    vecs[2] = '{w: 9'h0A5, exp_dc: 1'b0, exp_byte: 8'hA5};
    vecs[3] = '{w: 9'h180, exp_dc: 1'b1, exp_byte: 8'h80};
    vecs[4] = '{w: 9'h101, exp_dc: 1'b1, exp_byte: 8'h01};

    n_pass = 0; n_total = 0; cyc = 0;
    sys_rst_n = 1'b0;
    en_a = 1'b0; en_b = 1'b0; data_a = 9'h000; data_b = 9'h000;
    clear_mon();

    // Reset values: {cs_n, sclk, mosi, dc, wr_done, busy}
    repeat (3) step();
    chk("reset_outputs_a", int'({cs_w[0], sclk_w[0], mosi_w[0], dc_w[0], done_w[0], busy_w[0]}), 32'h20);
    chk("reset_outputs_b", int'({cs_w[1], sclk_w[1], mosi_w[1], dc_w[1], done_w[1], busy_w[1]}), 32'h20);
    sys_rst_n = 1'b1;
    repeat (2) step();

    // Table-driven single words on the CLK_DIV=2 instance.
    for (int i = 0; i < 5; i++) begin
      send(0, vecs[i].w, {vecs[i].exp_dc, vecs[i].exp_byte});
      repeat (2) step();
    end

    // CLK_DIV=1 boundary.
    send(1, 9'h1FF, 9'h1FF);
    repeat (2) step();

    // Back-to-back pixel words: producer holds en_write and steps data on wr_done.
    t0 = cyc + 1;
    e.w = 9'h1F8; e.t0 = t0;      q0.push_back(e);
    e.w = 9'h100; e.t0 = t0 + 36; q0.push_back(e);
    data_a = 9'h1F8; en_a = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (q0.size() <= 1) break;
      step();
    end
    chk("b2b_first_done", q0.size(), 1);
    data_a = 9'h100;
    step();
    chk("b2b_cs_gap", int'(cs_w[0]), int'(CS_AT_GAP));
    chk("b2b_busy_gap", int'(busy_w[0]), 1);
    step();
    chk("b2b_cs_after_recapture", int'(cs_w[0]), 0);
    chk("b2b_busy_after_recapture", int'(busy_w[0]), 1);
    wait_done(0);
    en_a = 1'b0;
    step();
    chk("b2b_cs_gap2", int'(cs_w[0]), int'(CS_AT_GAP));
    step();
    chk("b2b_cs_idle", int'(cs_w[0]), 1);
    chk("b2b_busy_idle", int'(busy_w[0]), 0);
    repeat (3) step();

    // Abandoned request: en_write dropped during SHIFT; word still completes once.
    e.w = 9'h155; e.t0 = cyc + 1; q0.push_back(e);
    data_a = 9'h155; en_a = 1'b1;
    repeat (12) step();
    en_a = 1'b0; data_a = 9'h0AA;
    wait_done(0);
    repeat (60) step();
    chk("abandon_busy_idle", int'(busy_w[0]), 0);
    chk("abandon_cs_idle", int'(cs_w[0]), 1);

    // Reset during bit 4: outputs return to reset values at once, no wr_done.
    e.w = 9'h0C3; e.t0 = cyc + 1; q0.push_back(e);
    data_a = 9'h0C3; en_a = 1'b1;
    step();
    en_a = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rises[0] >= 5) break;
      step();
    end
    chk("reached_bit4", rises[0], 5);
    sys_rst_n = 1'b0;
    #1;
    chk("midword_reset_outputs", int'({cs_w[0], sclk_w[0], mosi_w[0], dc_w[0], done_w[0], busy_w[0]}), 32'h20);
    clear_mon();
    repeat (3) step();
    sys_rst_n = 1'b1;
    repeat (40) step();
    send(0, 9'h1C3, 9'h1C3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
